window_stream_gen: RTL and testbench

//  Parametrised sliding-window generator for the input path. Takes a raster

---
 rtl/win_pkg.sv | 17 +
 rtl/line_buffer_ram.sv | 24 ++
 rtl/window_stream_gen.sv | 169 ++++++++++++++++
 tb/tb_window_stream_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared state encoding, defaults and lane indexing for the window generator
package win_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int K_DEF        = 3;
  localparam int PIX_W_DEF    = 16;
  localparam int MAX_COLS_DEF = 256;
  localparam int DIM_W_DEF    = 9;
  localparam int PLANE_W_DEF  = 8;

  // Element (r,c) of a KxK window lives at this lane; lane 0 sits in the LSBs.
  function automatic int lane(input int r, input int c, input int k = K_DEF);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - one-row pixel store, 1 write / 1 async read port, read returns pre-write data
module line_buffer_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 16,
  parameter int AW    = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are never cleared; the top only consumes a slot after it was rewritten this plane.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/window_stream_gen.sv
// rtl/window_stream_gen.sv - raster pixel stream to KxK sliding windows, stride 1 or 2, multi-plane
module window_stream_gen
  import win_pkg::*;
#(
  parameter int K        = K_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int MAX_COLS = MAX_COLS_DEF,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int PLANE_W  = PLANE_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DIM_W-1:0]     cfg_cols,
  input  logic [DIM_W-1:0]     cfg_rows,
  input  logic [PLANE_W-1:0]   cfg_planes,
  input  logic                 cfg_stride2,
  input  logic [PIX_W-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [K*K*PIX_W-1:0] win_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [DIM_W-1:0] K_D   = DIM_W'(K);
  localparam logic [DIM_W-1:0] KM1_D = DIM_W'(K - 1);
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_COLS);
  localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

  state_t               state_q;
  logic [DIM_W-1:0]     cols_q, rows_q, col_q, row_q;
  logic [PLANE_W-1:0]   planes_q, plane_q;
  logic                 stride2_q, pix_done_q;
  logic [K*K*PIX_W-1:0] win_q, win_d, out_q;
  logic                 out_valid_q, busy_q, done_q, cfg_err_q;

  logic                 out_free, accept, emit, cfg_ok;
  logic                 last_col, last_row, last_plane, par_ok;
  logic [PIX_W-1:0]     lb_rd [K-1];
  logic [PIX_W-1:0]     lb_wd [K-1];

  assign out_free   = ~out_valid_q | win_ready;
  assign in_ready   = (state_q == RUN) & ~pix_done_q & out_free;
  assign accept     = in_valid & in_ready;
  assign last_col   = (col_q == cols_q - ONE_D);
  assign last_row   = (row_q == rows_q - ONE_D);
  assign last_plane = (plane_q == planes_q - PLANE_W'(1));
  assign par_ok     = ~stride2_q | ((row_q[0] == KM1_D[0]) & (col_q[0] == KM1_D[0]));
  assign emit       = accept & (row_q >= KM1_D) & (col_q >= KM1_D) & par_ok;
  assign cfg_ok     = (cfg_cols >= K_D) & (cfg_cols <= MAX_D) & (cfg_rows >= K_D);

  // Buffer 0 holds the previous row; each deeper buffer takes what the one above it held.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_wd[j] = in_data;
    end else begin : g_chain
      assign lb_wd[j] = lb_rd[j-1];
    end
    line_buffer_ram #(.DEPTH(MAX_COLS), .W(PIX_W), .AW(DIM_W)) u_lb (
      .clk_i   (clk),
      .we_i    (accept),
      .waddr_i (col_q),
      .wdata_i (lb_wd[j]),
      .raddr_i (col_q),
      .rdata_o (lb_rd[j])
    );
  end

  // Shift the window one column left and append the freshly assembled column on the right.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[lane(r, c, K)*PIX_W +: PIX_W] = win_q[lane(r, c + 1, K)*PIX_W +: PIX_W];
      end
    end
    win_d[lane(K - 1, K - 1, K)*PIX_W +: PIX_W] = in_data;
    for (int j = 0; j < K - 1; j++) begin
      win_d[lane(K - 2 - j, K - 1, K)*PIX_W +: PIX_W] = lb_rd[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      planes_q    <= '0;
      stride2_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      plane_q     <= '0;
      pix_done_q  <= 1'b0;
      win_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q    <= RUN;
              busy_q     <= 1'b1;
              cols_q     <= cfg_cols;
              rows_q     <= cfg_rows;
              planes_q   <= (cfg_planes == '0) ? PLANE_W'(1) : cfg_planes;
              stride2_q  <= cfg_stride2;
              col_q      <= '0;
              row_q      <= '0;
              plane_q    <= '0;
              pix_done_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            win_q <= win_d;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q <= '0;
                if (last_plane) pix_done_q <= 1'b1;
                else            plane_q    <= plane_q + PLANE_W'(1);
              end else begin
                row_q <= row_q + ONE_D;
              end
            end else begin
              col_q <= col_q + ONE_D;
            end
          end
          if (emit) begin
            out_q       <= win_d;
            out_valid_q <= 1'b1;
          end else if (win_ready) begin
            out_valid_q <= 1'b0;
          end
          // All pixels are in; finish once nothing is left waiting in the output register.
          if (pix_done_q && out_free) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win_data  = out_q;
  assign win_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_window_stream_gen.sv
// tb/tb_window_stream_gen.sv - scoreboard bench for window_stream_gen with directed 3x3 scenarios
module tb_window_stream_gen;

  localparam int K = 3, PW = 16, DW = 9, PLW = 8, WW = K*K*PW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_cols = '0, cfg_rows = '0;
  logic [PLW-1:0] cfg_planes = '0;
  logic          cfg_stride2 = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] win_data;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic          busy, done, cfg_err;

  int total = 0, bad = 0;
  int done_cnt = 0;
  int cyc = 0;
  bit rdy_mode = 1'b0;
  bit hold_flag = 1'b0;
  logic [WW-1:0] held;
  logic [WW-1:0] sb [$];

  window_stream_gen #(.K(K), .PIX_W(PW), .MAX_COLS(256), .DIM_W(DW), .PLANE_W(PLW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_planes(cfg_planes), .cfg_stride2(cfg_stride2),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window whose top-left pixel value is tl in an image of the given row length.
  task automatic push_win(input int tl, input int cols);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*PW +: PW] = PW'(tl + r*cols + c);
    sb.push_back(w);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    win_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (hold_flag && reset_n) chk("stable_hold", win_data, held);
    hold_flag = 1'b0;
    if (reset_n && win_valid) begin
      if (win_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_window: got %h expected none", win_data);
        end else begin
          chk("window", win_data, sb.pop_front());
        end
      end else begin
        held = win_data;
        hold_flag = 1'b1;
      end
    end
    if (reset_n && done) begin
      done_cnt++;
      chk("done_after_last", WW'(sb.size()), WW'(0));
    end
  end

  task automatic do_start(input int cols, input int rows, input int planes, input bit s2);
    @(posedge clk); #2;
    start = 1'b1; cfg_cols = DW'(cols); cfg_rows = DW'(rows);
    cfg_planes = PLW'(planes); cfg_stride2 = s2;
    @(posedge clk); #2;
    start = 1'b0; cfg_cols = '0; cfg_rows = '0; cfg_stride2 = 1'b0;
  endtask

  task automatic stream(input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 3000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = PW'(i);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #2;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 3000) begin
      total++; bad++;
      $display("FAIL stream_timeout: got %0d pixels expected %0d", i, n);
    end
  endtask

  task automatic finish_run(input string name);
    int guard = 0;
    while (done_cnt == 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_done_cnt"}, WW'(done_cnt), WW'(1));
    chk({name, "_sb_empty"}, WW'(sb.size()), WW'(0));
    chk({name, "_busy_idle"}, WW'(busy), WW'(0));
    done_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_in_ready"}, WW'(in_ready), WW'(0));
    chk({name, "_win_valid"}, WW'(win_valid), WW'(0));
    chk({name, "_win_data"}, win_data, '0);
    chk({name, "_busy"}, WW'(busy), WW'(0));
    chk({name, "_done"}, WW'(done), WW'(0));
    chk({name, "_cfg_err"}, WW'(cfg_err), WW'(0));
  endtask

  task automatic run_4x4(input string name, input bit rnd);
    push_win(0, 4); push_win(1, 4); push_win(4, 4); push_win(5, 4);
    do_start(4, 4, 1, 1'b0);
    chk({name, "_busy_after_start"}, WW'(busy), WW'(1));
    stream(16, rnd);
    finish_run(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    reset_n = 1'b1;

    run_4x4("s1_4x4", 1'b0);

    push_win(0, 5); push_win(2, 5); push_win(10, 5); push_win(12, 5);
    do_start(5, 5, 1, 1'b1);
    stream(25, 1'b0);
    finish_run("s2_5x5");

    rdy_mode = 1'b1;
    run_4x4("bp_4x4", 1'b1);
    rdy_mode = 1'b0;

    push_win(0, 3); push_win(9, 3);
    do_start(3, 3, 2, 1'b0);
    stream(18, 1'b0);
    finish_run("planes2");

    @(posedge clk); #2;
    start = 1'b1; cfg_cols = DW'(2); cfg_rows = DW'(4); cfg_planes = PLW'(1);
    @(posedge clk); #2;
    start = 1'b0;
    chk("cfgerr_pulse", WW'(cfg_err), WW'(1));
    chk("cfgerr_busy", WW'(busy), WW'(0));
    chk("cfgerr_in_ready", WW'(in_ready), WW'(0));
    @(posedge clk); #2;
    chk("cfgerr_clear", WW'(cfg_err), WW'(0));
    chk("cfgerr_still_idle", WW'(busy), WW'(0));

    do_start(4, 4, 1, 1'b0);
    stream(7, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #2;
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    chk("midreset_no_done", WW'(done_cnt), WW'(0));
    chk("midreset_no_window", WW'(sb.size()), WW'(0));
    run_4x4("after_reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
